// File: rtl/color_scan_sequencer.sv
// rtl/color_scan_sequencer.sv - round-robin color sensor scan sequencer with settle, retry and timeout
// Optional COLOR_SCAN_CONTINUOUS_EN: scans restart from DONE without waiting for scanRequest.
module color_scan_sequencer #(
   parameter int NUM_CHANNELS   = 4,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scanRequest,
   input  logic       detectionComplete,
   input  logic [1:0] color,
   output logic       startDetection,
   output logic [1:0] channelSelect,
   output logic       scanBusy,
   output logic       scanDone,
   output logic [7:0] scanData,
   output logic       timeoutError
);
   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRIES + 2);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
   localparam logic [1:0]    LAST_CH      = 2'(NUM_CHANNELS - 1);
`ifdef COLOR_SCAN_CONTINUOUS_EN
   localparam logic CONTINUOUS = 1'b1;
`else
   localparam logic CONTINUOUS = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [1:0]    chan_q, chan_d;
   logic [7:0]    shadow_q, shadow_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ch_finish;
   logic [1:0]    ch_value;

   // One counter serves both settle and timeout; it restarts on every state change.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      retry_d   = retry_q;
      chan_d    = chan_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = err_q;
      ch_finish = 1'b0;
      ch_value  = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (scanRequest || CONTINUOUS) begin
               chan_d   = '0;
               shadow_d = '0;
               retry_d  = '0;
               err_d    = 1'b0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_START;
            else                      cnt_d   = cnt_q + 1'b1;
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (detectionComplete) begin
               ch_finish = 1'b1;
               ch_value  = color;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_START;
               end else begin
                  ch_finish = 1'b1;
                  err_d     = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            data_d = shadow_q;
            done_d = 1'b1;
            if (CONTINUOUS) begin
               chan_d   = '0;
               shadow_d = '0;
               retry_d  = '0;
               err_d    = 1'b0;
               state_d  = S_SETTLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A channel ends on a completion or an exhausted retry budget; both advance alike.
      if (ch_finish) begin
         shadow_d[{chan_q, 1'b0} +: 2] = ch_value;
         retry_d = '0;
         if (chan_q == LAST_CH) begin
            state_d = S_DONE;
         end else begin
            chan_d  = chan_q + 1'b1;
            state_d = S_SETTLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         retry_q  <= '0;
         chan_q   <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         chan_q   <= chan_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign startDetection = (state_q == S_START);
   assign channelSelect  = chan_q;
   assign scanBusy       = (state_q != S_IDLE);
   assign scanDone       = done_q;
   assign scanData       = data_q;
   assign timeoutError   = err_q;
endmodule

// File: tb/tb_color_scan_sequencer.sv
// tb/tb_color_scan_sequencer.sv - randomized scoreboard bench for color_scan_sequencer
// A reactive detector plans each attempt; the model predicts pulse times, channels and results.
module tb_color_scan_sequencer;
   localparam int NCH = 4, SETTLE = 4, TMO = 16, RETRIES = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       scanRequest;
   logic       detectionComplete;
   logic [1:0] color;
   logic       startDetection;
   logic [1:0] channelSelect;
   logic       scanBusy;
   logic       scanDone;
   logic [7:0] scanData;
   logic       timeoutError;

   always #5 clk = ~clk;

   color_scan_sequencer #(
      .NUM_CHANNELS(NCH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETRIES)
   ) dut (
      .clk(clk), .reset(reset), .scanRequest(scanRequest),
      .detectionComplete(detectionComplete), .color(color),
      .startDetection(startDetection), .channelSelect(channelSelect), .scanBusy(scanBusy),
      .scanDone(scanDone), .scanData(scanData), .timeoutError(timeoutError)
   );

   typedef struct packed { logic resp; int d; logic [1:0] c; } plan_t;

   int n_cmp = 0, n_bad = 0;
   plan_t script[$];
   int  cyc = 0, n_scans = 0;
   bit  m_busy = 0, m_final = 0, m_err = 0, stray = 0;
   int  m_ch = 0, m_att = 0, m_next = 0;
   logic [7:0] m_shadow = '0, m_data = '0;
   int  ch_pulses [NCH];
   int  cd = 0;
   logic [1:0] cd_col = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic plan_t next_plan();
      plan_t p;
      if (script.size() > 0) return script.pop_front();
      p.resp = ($urandom_range(0, 3) != 0);
      p.d    = ($urandom_range(0, 4) == 0) ? TMO : int'($urandom_range(1, TMO));
      p.c    = 2'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic end_channel(input int tend);
      if (m_ch == NCH - 1) begin
         m_final = 1;
         m_next  = tend + 2;
      end else begin
         m_ch++;
         m_att  = 0;
         m_next = tend + SETTLE + 1;
      end
   endtask

   task automatic on_pulse();
      plan_t p;
      check_eq("pulse_chan", 32'(channelSelect), 32'(m_ch));
      check_eq("pulse_busy", 32'(scanBusy), 32'd1);
      check_eq("pulse_err", 32'(timeoutError), 32'(m_err));
      check_eq("data_hold", 32'(scanData), 32'(m_data));
      ch_pulses[m_ch]++;
      p = next_plan();
      if (p.resp) begin
         cd     = p.d;
         cd_col = p.c;
         m_shadow[2*m_ch +: 2] = p.c;
         end_channel(cyc + p.d);
      end else begin
         m_att++;
         if (m_att <= RETRIES) begin
            m_next = cyc + TMO + 1;
         end else begin
            m_err = 1;
            end_channel(cyc + TMO);
         end
      end
   endtask

   task automatic step();
      bit exp_pulse, exp_done;
      if (reset && !m_busy && scanRequest) begin
         m_busy = 1; m_final = 0; m_err = 0; m_ch = 0; m_att = 0; m_shadow = '0;
         m_next = cyc + 1 + SETTLE;
         foreach (ch_pulses[i]) ch_pulses[i] = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      detectionComplete = 1'b0;
      color = 2'($urandom_range(0, 3));
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            detectionComplete = 1'b1;
            color = cd_col;
         end
      end
      if (stray) detectionComplete = 1'b1;
      exp_pulse = m_busy && !m_final && (cyc == m_next);
      exp_done  = m_busy && m_final && (cyc == m_next);
      if (startDetection || exp_pulse) begin
         check_eq("start_pulse", 32'(startDetection), 32'(exp_pulse));
         if (exp_pulse) on_pulse();
      end
      if (scanDone || exp_done) begin
         check_eq("scan_done", 32'(scanDone), 32'(exp_done));
         if (exp_done) begin
            check_eq("scan_data", 32'(scanData), 32'(m_shadow));
            check_eq("timeout_err", 32'(timeoutError), 32'(m_err));
            check_eq("done_idle", 32'(scanBusy), 32'd0);
            m_data = m_shadow;
            m_busy = 0;
            n_scans++;
         end
      end
      if (m_busy && cyc > m_next) begin
         check_eq("event_missing", 32'(cyc), 32'(m_next));
         m_busy = 0;
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (m_busy && n < limit) begin
         step();
         n++;
      end
      check_eq("scan_idle", 32'(m_busy), 32'd0);
      m_busy = 0;
   endtask

   task automatic run_scan();
      scanRequest = 1'b1;
      step();
      scanRequest = 1'b0;
      wait_idle(2000);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_start"}, 32'(startDetection), 32'd0);
      check_eq({tag, "_chan"}, 32'(channelSelect), 32'd0);
      check_eq({tag, "_busy"}, 32'(scanBusy), 32'd0);
      check_eq({tag, "_done"}, 32'(scanDone), 32'd0);
      check_eq({tag, "_data"}, 32'(scanData), 32'd0);
      check_eq({tag, "_err"}, 32'(timeoutError), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b0; scanRequest = 1'b0; detectionComplete = 1'b0; color = 2'd0;
      repeat (3) step();
      check_all_zero("rst");
      reset = 1'b1;
      repeat (2) step();
      stray = 1;
      step();
      stray = 0;
      repeat (3) step();
      check_eq("stray_busy", 32'(scanBusy), 32'd0);

      // Colors 3,0,1,2 each answered five cycles after the start pulse.
      script.push_back('{1'b1, 5, 2'd3});
      script.push_back('{1'b1, 5, 2'd0});
      script.push_back('{1'b1, 5, 2'd1});
      script.push_back('{1'b1, 5, 2'd2});
      run_scan();
      check_eq("basic_data", 32'(scanData), 32'h93);
      check_eq("basic_err", 32'(timeoutError), 32'd0);
      for (int i = 0; i < NCH; i++) check_eq("basic_pulses", 32'(ch_pulses[i]), 32'd1);

      // Channel 2 never answers: three attempts, then zero bits and a sticky error.
      script.push_back('{1'b1, 2, 2'd1});
      script.push_back('{1'b1, 2, 2'd2});
      repeat (3) script.push_back('{1'b0, 0, 2'd0});
      script.push_back('{1'b1, 3, 2'd3});
      run_scan();
      check_eq("tmo_data", 32'(scanData), 32'hC9);
      check_eq("tmo_err", 32'(timeoutError), 32'd1);
      check_eq("tmo_pulses", 32'(ch_pulses[2]), 32'd3);

      // Every answer lands in the same cycle the timeout expires.
      script.push_back('{1'b1, TMO, 2'd2});
      script.push_back('{1'b1, TMO, 2'd1});
      script.push_back('{1'b1, TMO, 2'd3});
      script.push_back('{1'b1, TMO, 2'd0});
      run_scan();
      check_eq("edge_data", 32'(scanData), 32'h36);
      check_eq("edge_err", 32'(timeoutError), 32'd0);
      for (int i = 0; i < NCH; i++) check_eq("edge_pulses", 32'(ch_pulses[i]), 32'd1);

      for (int s = 0; s < 20; s++) begin
         n = $urandom_range(0, 5);
         stray = ($urandom_range(0, 1) == 1);
         repeat (n) step();
         stray = 0;
         run_scan();
      end

      n = n_scans;
      scanRequest = 1'b1;
      for (int k = 0; k < 3000 && n_scans < n + 3; k++) step();
      scanRequest = 1'b0;
      check_eq("b2b_count", 32'(n_scans), 32'(n + 3));
      wait_idle(2000);

      // Abandon a scan while channel 1 is waiting for the detector.
      script.push_back('{1'b1, 3, 2'd1});
      script.push_back('{1'b0, 0, 2'd0});
      scanRequest = 1'b1;
      step();
      scanRequest = 1'b0;
      for (int k = 0; k < 200 && ch_pulses[1] == 0; k++) step();
      check_eq("mid_pulses", 32'(ch_pulses[1]), 32'd1);
      repeat (4) step();
      #2 reset = 1'b0;
      #1 check_all_zero("async_rst");
      m_busy = 0; m_data = '0; cd = 0; script.delete();
      repeat (3) step();
      reset = 1'b1;
      repeat (40) step();
      check_all_zero("post_rst");
      run_scan();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/color_scan_sequencer.md
COLOR_SCAN_SEQUENCER -- requirements
Module: color_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of sensor channels scanned per word; legal range 2..4.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024, idle cycles after each channel switch before a detection starts.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum cycles to wait for detectionComplete.
REQ-004 SHALL have parameter MAX_RETRIES, default 2, extra detection attempts per channel after a timeout.
REQ-005 SHALL have port: clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: scanRequest  input  1  level; starts a scan when sampled high in IDLE.
REQ-008 SHALL have port: detectionComplete  input  1  one-cycle pulse from the color detector.
REQ-009 SHALL have port: color  input  2  detector result, valid while detectionComplete is high.
REQ-010 SHALL have port: startDetection  output  1  one-cycle start pulse to the detector.
REQ-011 SHALL have port: channelSelect  output  2  sensor mux select (the active channel index).
REQ-012 SHALL have port: scanBusy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: scanDone  output  1  one-cycle pulse when scanData updates.
REQ-014 SHALL have port: scanData  output  8  last completed scan; channel n in bits [2n+1:2n]; unused upper bits 0.
REQ-015 SHALL have port: timeoutError  output  1  sticky; set on an exhausted channel, cleared on next scan start.

Function
REQ-016 SHALL implement states IDLE, SETTLE, START, WAIT, DONE.
REQ-017 IDLE with scanRequest=1 SHALL: clear channelSelect, the shadow word, the retry count and timeoutError, then go to SETTLE.
REQ-018 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then go to START.
REQ-019 START SHALL assert startDetection for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-020 WAIT with detectionComplete=1 SHALL write color into the shadow word at channelSelect and clear the retry count.
REQ-021 After a WAIT completion, SHALL go to DONE if channelSelect = NUM_CHANNELS-1; otherwise SHALL increment channelSelect and go to SETTLE.
REQ-022 WAIT with no completion for TIMEOUT_CYCLES cycles SHALL increment the retry count and go to START, while the count is at most MAX_RETRIES.
REQ-023 When the retry count is exhausted, SHALL write 2'b00 for that channel, set timeoutError and advance exactly as in REQ-021.
REQ-024 SHALL give detectionComplete priority when it arrives in the same cycle that the timeout expires.
REQ-025 SHALL ignore detectionComplete in every state except WAIT.
REQ-026 DONE SHALL copy the shadow word to scanData, pulse scanDone for one cycle and return to IDLE; total latency = 1 + NUM_CHANNELS*(SETTLE_CYCLES+2+detect time) + 1 cycles.
REQ-027 SHALL ignore scanRequest while scanBusy=1.
REQ-028 SHALL hold scanData stable between scanDone pulses.
REQ-029 SHALL size the counters to hold their parameter values without wrap-around.

Reset
REQ-030 While reset=0, state SHALL be IDLE and all outputs, counters and the shadow word SHALL be 0, independent of clk.
REQ-031 Reset mid-scan SHALL abandon the scan without emitting scanDone; the first scan after release SHALL start only on a new scanRequest.

Configuration
REQ-032 With COLOR_SCAN_CONTINUOUS_EN defined, DONE SHALL go directly to SETTLE with channelSelect=0 and timeoutError cleared, and the first scan after reset SHALL start without scanRequest.
REQ-033 Without COLOR_SCAN_CONTINUOUS_EN, behaviour SHALL be exactly REQ-017..REQ-031.

Verification (NUM_CHANNELS=4, SETTLE_CYCLES=4, TIMEOUT_CYCLES=16, MAX_RETRIES=2)
REQ-034 Model returns colors 3,0,1,2 after 5 cycles each -> 4 startDetection pulses on channels 0..3, scanData=8'b10010011, one scanDone, timeoutError=0.
REQ-035 Channel 2 never completes -> 3 START pulses on channel 2 spaced 17 cycles apart, channel 2 bits=00, timeoutError=1, scan still finishes.
REQ-036 Completion in the cycle the timeout expires -> color stored, no retry pulse.
REQ-037 reset low in WAIT of channel 1 -> all outputs 0 asynchronously, no scanDone, IDLE persists until scanRequest.
REQ-038 scanRequest held high throughout -> back-to-back scans, with scanRequest ignored while busy; with COLOR_SCAN_CONTINUOUS_EN and scanRequest=0 -> scans repeat after reset release.
